// File: rtl/hazard_ctrl.sv
// Hazard control for a 5-stage pipeline that resolves branches in ID.
// Produces operand forwarding selects for the ID stage, detects load-use
// hazards, sequences multi-cycle divides and flushes IF-ID on taken branches.
module hazard_ctrl #(
    parameter int unsigned DIV_CYCLES = 32
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [4:0] id_rs,
    input  logic [4:0] id_rt,
    input  logic       id_use_rs,
    input  logic       id_use_rt,
    input  logic [4:0] ex_rd,
    input  logic [4:0] mem_rd,
    input  logic [4:0] wb_rd,
    input  logic       ex_regwrite,
    input  logic       mem_regwrite,
    input  logic       wb_regwrite,
    input  logic       ex_memread,
    input  logic       id_div,
    input  logic       id_branch_taken,
    output logic [1:0] fwd_a_sel,
    output logic [1:0] fwd_b_sel,
    output logic       pc_stall,
    output logic       ifid_stall,
    output logic       idex_flush,
    output logic       ifid_flush,
    output logic       div_start,
    output logic       div_busy
);

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        DIV_WAIT = 2'd1,
        DIV_DONE = 2'd2
    } state_t;

    // Wait-counter reload: counting down to zero gives DIV_CYCLES wait cycles.
    localparam logic [5:0] DIV_LOAD = 6'(DIV_CYCLES - 1);

    state_t     state;
    state_t     state_next;
    logic [5:0] cnt;
    logic [5:0] cnt_next;
    logic       load_use;

    // Youngest producer wins; a load still in EX has no data to forward yet,
    // and register 0 is hardwired so it is never forwarded.
    function automatic logic [1:0] fwd_sel(input logic [4:0] src, input logic use_src);
        logic [1:0] sel;
        sel = 2'b00;
        if (use_src && (src != 5'd0)) begin
            if (ex_regwrite && !ex_memread && (ex_rd == src)) begin
                sel = 2'b01;
            end else if (mem_regwrite && (mem_rd == src)) begin
                sel = 2'b10;
            end else if (wb_regwrite && (wb_rd == src)) begin
                sel = 2'b11;
            end
        end
        return sel;
    endfunction

    // Forwarding selects stay live in every state so the divider can sample
    // its operands through them at launch.
    always_comb begin
        fwd_a_sel = fwd_sel(id_rs, id_use_rs);
        fwd_b_sel = fwd_sel(id_rt, id_use_rt);
    end

    // A load in EX whose destination is read by the ID instruction.
    always_comb begin
        load_use = ex_memread && ex_regwrite && (ex_rd != 5'd0) &&
                   ((id_use_rs && (ex_rd == id_rs)) || (id_use_rt && (ex_rd == id_rt)));
    end

    // State and wait counter; reset aborts any divide in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= RUN;
            cnt   <= 6'd0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
        end
    end

    // Next-state and stall/launch outputs; a load stall takes precedence over
    // accepting a divide, and the divide is retried on a later RUN cycle.
    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        pc_stall   = 1'b0;
        ifid_stall = 1'b0;
        idex_flush = 1'b0;
        div_start  = 1'b0;
        div_busy   = 1'b0;
        case (state)
            RUN: begin
                if (load_use) begin
                    pc_stall   = 1'b1;
                    ifid_stall = 1'b1;
                    idex_flush = 1'b1;
                end else if (id_div) begin
                    div_start  = 1'b1;
                    pc_stall   = 1'b1;
                    ifid_stall = 1'b1;
                    idex_flush = 1'b1;
                    cnt_next   = DIV_LOAD;
                    state_next = DIV_WAIT;
                end
            end
            DIV_WAIT: begin
                pc_stall   = 1'b1;
                ifid_stall = 1'b1;
                idex_flush = 1'b1;
                div_busy   = 1'b1;
                if (cnt == 6'd0) begin
                    state_next = DIV_DONE;
                end else begin
                    cnt_next = cnt - 6'd1;
                end
            end
            DIV_DONE: begin
                state_next = RUN;
            end
            default: begin
                state_next = RUN;
            end
        endcase
    end

    // A stalled branch has not actually resolved, so it must not flush.
    assign ifid_flush = id_branch_taken & ~pc_stall;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl with a 4-cycle divide.
// Expected outputs are queued as each cycle's inputs are driven and compared
// shortly after, well away from the rising edge.
module tb_hazard_ctrl;

    logic       clk;
    logic       rst_n;
    logic [4:0] id_rs, id_rt, ex_rd, mem_rd, wb_rd;
    logic       id_use_rs, id_use_rt;
    logic       ex_regwrite, mem_regwrite, wb_regwrite;
    logic       ex_memread, id_div, id_branch_taken;
    logic [1:0] fwd_a_sel, fwd_b_sel;
    logic       pc_stall, ifid_stall, idex_flush, ifid_flush, div_start, div_busy;

    typedef struct {
        string      tag;
        logic [9:0] exp;
    } sb_t;

    sb_t sb[$];
    int  testsRun = 0;
    int  testsFailed = 0;

    hazard_ctrl #(.DIV_CYCLES(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .id_rs(id_rs), .id_rt(id_rt), .id_use_rs(id_use_rs), .id_use_rt(id_use_rt),
        .ex_rd(ex_rd), .mem_rd(mem_rd), .wb_rd(wb_rd),
        .ex_regwrite(ex_regwrite), .mem_regwrite(mem_regwrite), .wb_regwrite(wb_regwrite),
        .ex_memread(ex_memread), .id_div(id_div), .id_branch_taken(id_branch_taken),
        .fwd_a_sel(fwd_a_sel), .fwd_b_sel(fwd_b_sel),
        .pc_stall(pc_stall), .ifid_stall(ifid_stall), .idex_flush(idex_flush),
        .ifid_flush(ifid_flush), .div_start(div_start), .div_busy(div_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [9:0] obs, input logic [9:0] exp);
        testsRun++;
        if (obs !== exp) begin
            testsFailed++;
            $display("[TB] FAIL %s: got %b expected %b (fa fb pc ifs idf iff ds db)", tag, obs, exp);
        end
    endtask

    // Reference forwarding decision used for the randomized patterns.
    function automatic logic [1:0] refFwd(input logic [4:0] r, input logic use_r);
        if (!use_r || r == 5'd0) return 2'b00;
        if (ex_regwrite && !ex_memread && ex_rd == r) return 2'b01;
        if (mem_regwrite && mem_rd == r) return 2'b10;
        if (wb_regwrite && wb_rd == r) return 2'b11;
        return 2'b00;
    endfunction

    // Called at a falling edge after the inputs are set: queue the expectation
    // {fwd_a, fwd_b} / {pc_stall, ifid_stall, idex_flush, ifid_flush, div_start, div_busy}.
    task automatic applyStimulus(input string tag, input logic [3:0] expFwd, input logic [5:0] expCtl);
        sb_t e;
        e.tag = tag;
        e.exp = {expFwd, expCtl};
        sb.push_back(e);
        @(negedge clk);
    endtask

    task automatic clearInputs();
        id_rs = 0; id_rt = 0; id_use_rs = 0; id_use_rt = 0;
        ex_rd = 0; mem_rd = 0; wb_rd = 0;
        ex_regwrite = 0; mem_regwrite = 0; wb_regwrite = 0;
        ex_memread = 0; id_div = 0; id_branch_taken = 0;
    endtask

    // Monitor: sample 2 time units after each falling edge.
    initial begin
        sb_t e;
        forever begin
            @(negedge clk);
            #2;
            if (sb.size() > 0) begin
                e = sb.pop_front();
                checkOutput(e.tag, {fwd_a_sel, fwd_b_sel, pc_stall, ifid_stall, idex_flush,
                                    ifid_flush, div_start, div_busy}, e.exp);
            end
        end
    end

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        rst_n = 1'b0;
        clearInputs();
        @(negedge clk);

        // Reset state
        applyStimulus("reset0", 4'b0000, 6'b000000);
        applyStimulus("reset1", 4'b0000, 6'b000000);
        rst_n = 1'b1;
        applyStimulus("idle", 4'b0000, 6'b000000);

        // Forwarding priority EX > MEM > WB
        id_rs = 5; id_use_rs = 1; id_rt = 5; id_use_rt = 1;
        ex_rd = 5; ex_regwrite = 1; mem_rd = 5; mem_regwrite = 1;
        applyStimulus("fwd_ex", 4'b0101, 6'b000000);
        ex_regwrite = 0;
        applyStimulus("fwd_mem", 4'b1010, 6'b000000);
        mem_regwrite = 0; wb_rd = 5; wb_regwrite = 1;
        applyStimulus("fwd_wb", 4'b1111, 6'b000000);
        id_use_rs = 0;
        applyStimulus("fwd_unused_rs", 4'b0011, 6'b000000);

        // Register 0 never forwarded, never stalls
        clearInputs();
        id_use_rs = 1; id_use_rt = 1;
        ex_regwrite = 1; mem_regwrite = 1; wb_regwrite = 1; ex_memread = 1;
        applyStimulus("reg0", 4'b0000, 6'b000000);

        // Load-use on rt
        clearInputs();
        ex_memread = 1; ex_regwrite = 1; ex_rd = 7; id_rt = 7; id_use_rt = 1;
        applyStimulus("loaduse0", 4'b0000, 6'b111000);
        mem_rd = 7; mem_regwrite = 1;
        applyStimulus("loaduse1", 4'b0010, 6'b111000);
        ex_memread = 0;
        applyStimulus("loaduse_gone", 4'b0001, 6'b000000);

        // Stalled branch does not flush, then flushes once resolved
        ex_memread = 1; mem_regwrite = 0; id_branch_taken = 1;
        applyStimulus("br_stalled", 4'b0000, 6'b111000);
        ex_memread = 0;
        applyStimulus("br_flush", 4'b0001, 6'b000100);

        // Load stall beats divide; divide accepted next RUN cycle
        clearInputs();
        ex_memread = 1; ex_regwrite = 1; ex_rd = 9; id_rs = 9; id_use_rs = 1; id_div = 1;
        applyStimulus("ld_vs_div", 4'b0000, 6'b111000);
        ex_memread = 0;
        applyStimulus("div_accept", 4'b0100, 6'b111010);
        clearInputs();
        id_div = 1;
        applyStimulus("div_wait1", 4'b0000, 6'b111001);
        id_rs = 3; id_use_rs = 1; wb_rd = 3; wb_regwrite = 1; id_branch_taken = 1;
        applyStimulus("div_wait2_fwd", 4'b1100, 6'b111001);
        clearInputs();
        id_div = 1;
        applyStimulus("div_wait3", 4'b0000, 6'b111001);
        applyStimulus("div_wait4", 4'b0000, 6'b111001);
        applyStimulus("div_done", 4'b0000, 6'b000000);
        applyStimulus("div_restart", 4'b0000, 6'b111010);

        // Reset on the second wait cycle aborts the divide
        applyStimulus("div2_wait1", 4'b0000, 6'b111001);
        rst_n = 1'b0; id_div = 0;
        applyStimulus("abort_reset", 4'b0000, 6'b000000);
        rst_n = 1'b1;
        applyStimulus("abort_run0", 4'b0000, 6'b000000);
        applyStimulus("abort_run1", 4'b0000, 6'b000000);
        id_div = 1;
        applyStimulus("div3_accept", 4'b0000, 6'b111010);
        id_div = 0;
        for (int i = 0; i < 4; i++) applyStimulus("div3_wait", 4'b0000, 6'b111001);
        id_branch_taken = 1;
        applyStimulus("div3_done_br", 4'b0000, 6'b000100);
        id_branch_taken = 0;
        applyStimulus("div3_run", 4'b0000, 6'b000000);

        // Randomized forwarding patterns, no hazards present
        for (int i = 0; i < 24; i++) begin
            id_rs = 5'($urandom_range(0, 3)); id_rt = 5'($urandom_range(0, 3));
            ex_rd = 5'($urandom_range(0, 3)); mem_rd = 5'($urandom_range(0, 3));
            wb_rd = 5'($urandom_range(0, 3));
            id_use_rs = 1'($urandom_range(0, 1)); id_use_rt = 1'($urandom_range(0, 1));
            ex_regwrite = 1'($urandom_range(0, 1)); mem_regwrite = 1'($urandom_range(0, 1));
            wb_regwrite = 1'($urandom_range(0, 1));
            applyStimulus("fwd_rand", {refFwd(id_rs, id_use_rs), refFwd(id_rt, id_use_rt)}, 6'b000000);
        end

        @(negedge clk);
        #3;
        testsRun++;
        if (sb.size() != 0) begin
            testsFailed++;
            $display("[TB] FAIL scoreboard_drain: got %0d pending expected 0", sb.size());
        end
        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
